// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - six-digit HEX page sequencer for live/high score with game-over flash
// Optional feature macro: SCORE_LEADING_ZERO_BLANK_EN (blank HEX1 when a displayed tens digit is 0)
module score_display_ctrl #(
    parameter int TICK_DIV   = 25000000,
    parameter int OVER_TICKS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       point,
    input  logic       game_over,
    output logic [7:0] HEX5,
    output logic [7:0] HEX4,
    output logic [7:0] HEX3,
    output logic [7:0] HEX2,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0,
    output logic       new_best,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int TCNT_W = (OVER_TICKS > 1) ? $clog2(OVER_TICKS) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(OVER_TICKS - 1);

    localparam logic [7:0] G_S     = 8'h92;
    localparam logic [7:0] G_C     = 8'hA7;
    localparam logic [7:0] G_R     = 8'hAF;
    localparam logic [7:0] G_H     = 8'h89;
    localparam logic [7:0] G_I     = 8'hFB;
    localparam logic [7:0] G_BLANK = 8'hFF;
    localparam logic [7:0] G_ZERO  = 8'hC0;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] RST_HEX1 = G_BLANK;
`else
    localparam logic [7:0] RST_HEX1 = G_ZERO;
`endif

    state_t              state;
    logic [3:0]          score_tens;
    logic [3:0]          score_ones;
    logic [3:0]          high_tens;
    logic [3:0]          high_ones;
    logic [DIV_W-1:0]    div_cnt;
    logic [TCNT_W-1:0]   tick_cnt;
    logic                blink;

    logic [3:0]          inc_tens;
    logic [3:0]          inc_ones;
    logic                score_full;
    logic                tick;
    logic                last_tick;

    logic [7:0]          page5;
    logic [7:0]          page4;
    logic [7:0]          page3;
    logic [7:0]          page2;
    logic [7:0]          page1;
    logic [7:0]          page0;

    // Digit to active-low segment glyph; DP always off
    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // Tens digit glyph, optionally suppressing a leading zero
    function automatic logic [7:0] tens_glyph(input logic [3:0] d);
        logic [7:0] g;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        g = (d == 4'd0) ? G_BLANK : digit_glyph(d);
`else
        g = digit_glyph(d);
`endif
        return g;
    endfunction

    assign score_full = (score_tens == 4'd9) && (score_ones == 4'd9);
    assign tick       = (div_cnt == DIV_MAX);
    assign last_tick  = (tick_cnt == TCNT_MAX);
    assign phase      = state;

    // BCD score after this cycle's point (saturating at 99); used for update and high compare
    always_comb begin
        inc_tens = score_tens;
        inc_ones = score_ones;
        if (point && !score_full) begin
            if (score_ones == 4'd9) begin
                inc_ones = 4'd0;
                inc_tens = score_tens + 4'd1;
            end else begin
                inc_ones = score_ones + 4'd1;
            end
        end
    end

    // Game phase FSM with score, high score, flash divider and blink state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            high_tens  <= 4'd0;
            high_ones  <= 4'd0;
            new_best   <= 1'b0;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            blink      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    div_cnt  <= '0;
                    tick_cnt <= '0;
                    blink    <= 1'b0;
                    if (start) begin
                        state      <= ST_PLAY;
                        score_tens <= 4'd0;
                        score_ones <= 4'd0;
                        new_best   <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    div_cnt  <= '0;
                    tick_cnt <= '0;
                    blink    <= 1'b0;
                    if (point) begin
                        score_tens <= inc_tens;
                        score_ones <= inc_ones;
                    end
                    if (game_over) begin
                        state <= ST_OVER;
                        // BCD pairs order the same as their decimal values
                        if ({inc_tens, inc_ones} > {high_tens, high_ones}) begin
                            high_tens <= inc_tens;
                            high_ones <= inc_ones;
                            new_best  <= 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state      <= ST_PLAY;
                        score_tens <= 4'd0;
                        score_ones <= 4'd0;
                        new_best   <= 1'b0;
                        div_cnt    <= '0;
                        tick_cnt   <= '0;
                        blink      <= 1'b0;
                    end else if (tick) begin
                        div_cnt <= '0;
                        if (last_tick) begin
                            state    <= ST_IDLE;
                            tick_cnt <= '0;
                            blink    <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                            blink    <= ~blink;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Page selection from the current state; registered on the next edge
    always_comb begin
        page5 = G_H;
        page4 = G_I;
        page3 = G_BLANK;
        page2 = G_BLANK;
        page1 = tens_glyph(high_tens);
        page0 = digit_glyph(high_ones);
        if (state == ST_PLAY || state == ST_OVER) begin
            page5 = G_S;
            page4 = G_C;
            page3 = G_R;
            page2 = G_BLANK;
            page1 = tens_glyph(score_tens);
            page0 = digit_glyph(score_ones);
            if (state == ST_OVER && new_best && blink) begin
                page1 = G_BLANK;
                page0 = G_BLANK;
            end
        end
    end

    // One registered output stage for the segment drives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HEX5 <= G_H;
            HEX4 <= G_I;
            HEX3 <= G_BLANK;
            HEX2 <= G_BLANK;
            HEX1 <= RST_HEX1;
            HEX0 <= G_ZERO;
        end else begin
            HEX5 <= page5;
            HEX4 <= page4;
            HEX3 <= page3;
            HEX2 <= page2;
            HEX1 <= page1;
            HEX0 <= page0;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - directed table and sequence bench for score_display_ctrl
module tb_score_display_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       point = 1'b0;
    logic       game_over = 1'b0;
    logic [7:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
    logic       new_best;
    logic [1:0] phase;

    int n_vec  = 0;
    int n_fail = 0;

    score_display_ctrl #(.TICK_DIV(4), .OVER_TICKS(6)) dut (
        .clk(clk), .rst(rst), .start(start), .point(point), .game_over(game_over),
        .HEX5(HEX5), .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
        .new_best(new_best), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       p;
        logic       g;
        int         rpt;
        logic [1:0] ph;
        logic       nb;
        logic [7:0] h5, h4, h3, h2, h1, h0;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [7:0] fx1(input logic [7:0] v);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        return (v == 8'hC0) ? 8'hFF : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chk_page(input string nm, input logic [7:0] e5, input logic [7:0] e4,
                            input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
        chk({nm, " HEX5"}, HEX5, e5);
        chk({nm, " HEX4"}, HEX4, e4);
        chk({nm, " HEX3"}, HEX3, e3);
        chk({nm, " HEX2"}, HEX2, e2);
        chk({nm, " HEX1"}, HEX1, e1);
        chk({nm, " HEX0"}, HEX0, e0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic p, input logic g);
        start = s;
        point = p;
        game_over = g;
        @(posedge clk);
        #1;
        start = 1'b0;
        point = 1'b0;
        game_over = 1'b0;
    endtask

    task automatic pts(input int n);
        point = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        point = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int w;
        w = 0;
        while (phase != 2'd0 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk(nm, {6'd0, phase}, 8'd0);
    endtask

    initial begin
        // start, point, game_over, repeat, phase, new_best, HEX5..HEX0
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1,   2'd1, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hC0, 8'hC0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 12,  2'd1, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hF9, 8'hA4};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1,   2'd1, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hF9, 8'hA4};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1,   2'd2, 1'b1, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hF9, 8'hA4};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1,   2'd1, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hC0, 8'hC0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 5,   2'd1, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hC0, 8'h92};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1,   2'd2, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hC0, 8'h92};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1,   2'd1, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hC0, 8'hC0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 105, 2'd1, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'h90, 8'h90};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1,   2'd2, 1'b1, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'h90, 8'h90};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1,   2'd1, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hC0, 8'hC0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 9,   2'd1, 1'b0, 8'h92, 8'hA7, 8'hAF, 8'hFF, 8'hC0, 8'h90};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_page("reset", 8'h89, 8'hFB, 8'hFF, 8'hFF, fx1(8'hC0), 8'hC0);
        chk("reset phase", {6'd0, phase}, 8'd0);
        chk("reset new_best", {7'd0, new_best}, 8'd0);

        // Full flash of a new best of 12, then a second game of 05
        pulse(1'b1, 1'b0, 1'b0);
        pts(12);
        pulse(1'b0, 1'b0, 1'b1);
        chk("over entry phase", {6'd0, phase}, 8'd2);
        chk("over entry new_best", {7'd0, new_best}, 8'd1);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("flash phase k=%0d", k), {6'd0, phase}, (k < 24) ? 8'd2 : 8'd0);
            if ((((k - 1) / 4) % 2) == 1) begin
                chk($sformatf("flash HEX1 k=%0d", k), HEX1, 8'hFF);
                chk($sformatf("flash HEX0 k=%0d", k), HEX0, 8'hFF);
            end else begin
                chk($sformatf("flash HEX1 k=%0d", k), HEX1, 8'hF9);
                chk($sformatf("flash HEX0 k=%0d", k), HEX0, 8'hA4);
            end
        end
        @(posedge clk);
        #1;
        chk_page("idle high 12", 8'h89, 8'hFB, 8'hFF, 8'hFF, 8'hF9, 8'hA4);
        pulse(1'b1, 1'b0, 1'b0);
        pts(5);
        pulse(1'b0, 1'b0, 1'b1);
        chk("game2 new_best", {7'd0, new_best}, 8'd0);
        wait_idle("game2 reach idle");
        @(posedge clk);
        #1;
        chk_page("game2 high kept", 8'h89, 8'hFB, 8'hFF, 8'hFF, 8'hF9, 8'hA4);

        // Point and game_over together at 09 against high 09
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pts(9);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("restart phase", {6'd0, phase}, 8'd1);
        pts(9);
        pulse(1'b1, 1'b1, 1'b1);
        chk("simul phase", {6'd0, phase}, 8'd2);
        chk("simul new_best", {7'd0, new_best}, 8'd1);
        @(posedge clk);
        #1;
        chk("simul HEX1", HEX1, 8'hF9);
        chk("simul HEX0", HEX0, 8'hC0);
        wait_idle("simul reach idle");
        @(posedge clk);
        #1;
        chk_page("simul high 10", 8'h89, 8'hFB, 8'hFF, 8'hFF, 8'hF9, 8'hC0);

        // Asynchronous reset in the middle of a flash
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pts(12);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_page("async reset", 8'h89, 8'hFB, 8'hFF, 8'hFF, fx1(8'hC0), 8'hC0);
        chk("async reset phase", {6'd0, phase}, 8'd0);
        chk("async reset new_best", {7'd0, new_best}, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Start coinciding with the 3rd tick of OVER
        pulse(1'b1, 1'b0, 1'b0);
        pts(3);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        chk("pre-abort phase", {6'd0, phase}, 8'd2);
        pulse(1'b1, 1'b0, 1'b0);
        chk("abort phase", {6'd0, phase}, 8'd1);
        chk("abort new_best", {7'd0, new_best}, 8'd0);
        @(posedge clk);
        #1;
        chk_page("abort page", 8'h92, 8'hA7, 8'hAF, 8'hFF, fx1(8'hC0), 8'hC0);

        // Table-driven vectors from a fresh reset
        do_reset();
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].s;
            point = tbl[i].p;
            game_over = tbl[i].g;
            repeat (tbl[i].rpt) @(posedge clk);
            #1;
            start = 1'b0;
            point = 1'b0;
            game_over = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d phase", i), {6'd0, phase}, {6'd0, tbl[i].ph});
            chk($sformatf("vec%0d new_best", i), {7'd0, new_best}, {7'd0, tbl[i].nb});
            chk_page($sformatf("vec%0d", i), tbl[i].h5, tbl[i].h4, tbl[i].h3, tbl[i].h2,
                     fx1(tbl[i].h1), tbl[i].h0);
        end

        // Single-digit score of 7
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pts(7);
        @(posedge clk);
        #1;
        chk("score7 HEX1", HEX1, fx1(8'hC0));
        chk("score7 HEX0", HEX0, 8'hF8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
